productor_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one `productor_top` 8x8 multiplier (low 8 bits of the product) among NUM_REQ requesters.
- Requesters present operand pairs over valid/ready; the block grants one and registers its operands. It then drives the multiplier, registers the result and returns it with the requester ID over a valid/ready response channel.
- Sits between the ALU operand sources and the shared `productor_top` instance.

---
 rtl/productor_pkg.sv | 14 +
 rtl/productor_rr_pick.sv | 45 ++++
 rtl/productor_top.sv | 14 +
 rtl/productor_arbiter.sv | 103 ++++++++++
 tb/tb_productor_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/productor_pkg.sv
// Shared constants and FSM encoding for the productor multiplier arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package productor_pkg;

  localparam int PROD_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/productor_rr_pick.sv
// Combinational request picker: round-robin after last_grant, or lowest index
// first when PRODUCTOR_ARB_FIXED_PRIO_EN is defined. Latency: combinational. Backpressure: none.
module productor_rr_pick
  import productor_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec,
`ifndef PRODUCTOR_ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]    last_grant,
`endif
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
`ifdef PRODUCTOR_ARB_FIXED_PRIO_EN
    // Scan high to low so the lowest valid index is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_vec[ID_W'(i)]) begin
        grant_idx = ID_W'(i);
        any_valid = 1'b1;
      end
    end
`else
    // Scan farthest-from-pointer first so the nearest candidate wins.
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (req_vec[ID_W'(idx)]) begin
        grant_idx = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
`endif
    if (any_valid) grant_oh[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/productor_top.sv
// Shared 8x8 multiplier datapath; product truncated to the low 8 bits.
// Latency: combinational.
// Backpressure: none.
module productor_top
  import productor_pkg::*;
(
  input  logic [PROD_DATA_W-1:0] a_i,
  input  logic [PROD_DATA_W-1:0] b_i,
  output logic [PROD_DATA_W-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/productor_arbiter.sv
// Arbitrates NUM_REQ requesters onto one productor_top multiplier (macro PRODUCTOR_ARB_FIXED_PRIO_EN selects fixed priority).
// Latency: accept at t -> rsp_valid_o at t+2; one issue every 3 cycles minimum.
// Backpressure: response held in RESP until rsp_ready_i; no requests accepted meanwhile.
module productor_arbiter
  import productor_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*PROD_DATA_W-1:0] req_data0_i,
  input  logic [NUM_REQ*PROD_DATA_W-1:0] req_data1_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [PROD_DATA_W-1:0]         rsp_result_o,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic                           busy_o
);

  state_t                 state_q, state_d;
  logic [PROD_DATA_W-1:0] op0_q, op1_q, prod;
  logic [PROD_DATA_W-1:0] sel0, sel1;
  logic [ID_W-1:0]        id_q;
  logic [NUM_REQ-1:0]     grant_oh;
  logic [ID_W-1:0]        grant_idx;
  logic                   any_valid;
  logic                   accept;

`ifndef PRODUCTOR_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]        last_grant_q;
`endif

  productor_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_vec    (req_valid_i),
`ifndef PRODUCTOR_ARB_FIXED_PRIO_EN
    .last_grant (last_grant_q),
`endif
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx),
    .any_valid  (any_valid)
  );

  productor_top u_mul (
    .a_i (op0_q),
    .b_i (op1_q),
    .p_o (prod)
  );

  assign sel0   = req_data0_i[int'(grant_idx)*PROD_DATA_W +: PROD_DATA_W];
  assign sel1   = req_data1_i[int'(grant_idx)*PROD_DATA_W +: PROD_DATA_W];
  assign accept = (state_q == IDLE) && any_valid;
  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = grant_oh;
        if (any_valid) state_d = CALC;
      end
      CALC: state_d = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op0_q        <= '0;
      op1_q        <= '0;
      id_q         <= '0;
      rsp_result_o <= '0;
      rsp_id_o     <= '0;
`ifndef PRODUCTOR_ARB_FIXED_PRIO_EN
      last_grant_q <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        op0_q <= sel0;
        op1_q <= sel1;
        id_q  <= grant_idx;
`ifndef PRODUCTOR_ARB_FIXED_PRIO_EN
        last_grant_q <= grant_idx;
`endif
      end
      if (state_q == CALC) begin
        rsp_result_o <= prod;
        rsp_id_o     <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_productor_arbiter.sv
// Directed self-checking bench for productor_arbiter (4 requesters).
module tb_productor_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [31:0] req_data0_i;
  logic [31:0] req_data1_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [7:0]  rsp_result_o;
  logic [1:0]  rsp_id_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  productor_arbiter #(.NUM_REQ(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_data0_i  (req_data0_i),
    .req_data1_i  (req_data1_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_id_o     (rsp_id_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"},  32'(req_ready_o),  32'h0);
    chk({tag, "_valid"},  32'(rsp_valid_o),  32'h0);
    chk({tag, "_result"}, 32'(rsp_result_o), 32'h0);
    chk({tag, "_id"},     32'(rsp_id_o),     32'h0);
    chk({tag, "_busy"},   32'(busy_o),       32'h0);
  endtask

  logic [1:0] exp_id;
  logic [7:0] exp_res;

  initial begin
    rst_i       = 1'b1;
    req_valid_i = '0;
    req_data0_i = '0;
    req_data1_i = '0;
    rsp_ready_i = 1'b1;
    step();
    step();
    chk_zero("reset");
    rst_i = 1'b0;

    // Single request: 12*11 = 132 = 0x84
    req_data0_i = {8'd0, 8'd0, 8'd0, 8'd12};
    req_data1_i = {8'd0, 8'd0, 8'd0, 8'd11};
    req_valid_i = 4'b0001;
    #1;
    chk("single_ready", 32'(req_ready_o), 32'h1);
    chk("single_idle_busy", 32'(busy_o), 32'h0);
    step();
    req_valid_i = 4'b0000;
    #1;
    chk("single_calc_busy", 32'(busy_o), 32'h1);
    chk("single_calc_valid", 32'(rsp_valid_o), 32'h0);
    step();
    chk("single_valid", 32'(rsp_valid_o), 32'h1);
    chk("single_result", 32'(rsp_result_o), 32'h84);
    chk("single_id", 32'(rsp_id_o), 32'h0);
    step();
    chk("single_done_valid", 32'(rsp_valid_o), 32'h0);
    chk("single_done_busy", 32'(busy_o), 32'h0);

    // Truncation: requester 2, 20*20 = 400 -> 0x90
    req_data0_i = {8'd0, 8'd20, 8'd0, 8'd0};
    req_data1_i = {8'd0, 8'd20, 8'd0, 8'd0};
    req_valid_i = 4'b0100;
    #1;
    chk("trunc_ready", 32'(req_ready_o), 32'h4);
    step();
    req_valid_i = 4'b0000;
    step();
    chk("trunc_valid", 32'(rsp_valid_o), 32'h1);
    chk("trunc_result", 32'(rsp_result_o), 32'h90);
    chk("trunc_id", 32'(rsp_id_o), 32'h2);
    step();

    // Fresh reset so the pointer restarts at requester 0.
    rst_i = 1'b1;
    #2;
    rst_i = 1'b0;
    step();

    // All four valid: requester k computes (k+1)*3.
    req_data0_i = {8'd4, 8'd3, 8'd2, 8'd1};
    req_data1_i = {8'd3, 8'd3, 8'd3, 8'd3};
    req_valid_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
`ifdef PRODUCTOR_ARB_FIXED_PRIO_EN
      exp_id = 2'd0;
`else
      exp_id = 2'(i % 4);
`endif
      exp_res = 8'((int'(exp_id) + 1) * 3);
      #1;
      chk("rr_idle_valid", 32'(rsp_valid_o), 32'h0);
      chk("rr_ready", 32'(req_ready_o), 32'(4'b0001 << exp_id));
      step();
      chk("rr_calc_ready", 32'(req_ready_o), 32'h0);
      step();
      chk("rr_valid", 32'(rsp_valid_o), 32'h1);
      chk("rr_id", 32'(rsp_id_o), 32'(exp_id));
      chk("rr_result", 32'(rsp_result_o), 32'(exp_res));
      step();
    end

    // Backpressure: requester 1 computes 7*9 = 63 = 0x3F.
    req_data0_i = {8'd4, 8'd3, 8'd7, 8'd1};
    req_data1_i = {8'd3, 8'd3, 8'd9, 8'd3};
    req_valid_i = 4'b0010;
    rsp_ready_i = 1'b0;
    #1;
    chk("bp_ready", 32'(req_ready_o), 32'h2);
    step();
    req_valid_i = 4'b1000;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(rsp_valid_o), 32'h1);
      chk("bp_hold_result", 32'(rsp_result_o), 32'h3f);
      chk("bp_hold_id", 32'(rsp_id_o), 32'h1);
      chk("bp_hold_ready", 32'(req_ready_o), 32'h0);
      chk("bp_hold_busy", 32'(busy_o), 32'h1);
      step();
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_release_valid", 32'(rsp_valid_o), 32'h1);
    step();
    chk("bp_idle_valid", 32'(rsp_valid_o), 32'h0);
    chk("bp_idle_busy", 32'(busy_o), 32'h0);
    chk("bp_next_ready", 32'(req_ready_o), 32'h8);
    step();
    req_valid_i = 4'b0000;
    step();
    chk("bp_next_result", 32'(rsp_result_o), 32'h0c);
    chk("bp_next_id", 32'(rsp_id_o), 32'h3);
    step();

    // Reset while in CALC.
    req_valid_i = 4'b0001;
    step();
    req_valid_i = 4'b0000;
    #1;
    chk("mid_calc_busy", 32'(busy_o), 32'h1);
    rst_i = 1'b1;
    #1;
    chk_zero("mid_reset");
    step();
    rst_i       = 1'b0;
    req_valid_i = 4'b1010;
    #1;
    chk("post_reset_ready", 32'(req_ready_o), 32'h2);
    chk("post_reset_valid", 32'(rsp_valid_o), 32'h0);
    step();
    req_valid_i = 4'b0000;
    #1;
    chk("post_reset_calc_valid", 32'(rsp_valid_o), 32'h0);
    step();
    chk("post_reset_rsp_valid", 32'(rsp_valid_o), 32'h1);
    chk("post_reset_rsp_id", 32'(rsp_id_o), 32'h1);
    chk("post_reset_rsp_result", 32'(rsp_result_o), 32'h3f);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
